phys_reg_free_list: RTL and testbench
=====================================

Name: phys_reg_free_list

Overview:
- Circular free list of physical register tags. It sits between the ROB retire port and the rename stage.
- The rename stage pops one free physical tag per cycle to use as a new destination register.
- The ROB returns up to two freed tags (old_dr of retiring instructions) per cycle.
- An allocation bitmap rejects double-frees and frees of illegal tags, and raises a sticky error flag.

Parameters:
- NUM_PREGS, 64, number of physical registers; must be a power of 2.
- NUM_AREGS, 32, architectural registers; p0..p(NUM_AREGS-1) are mapped at reset and are never in the list at reset.
- TAG_W, 6, physical tag width, equal to log2(NUM_PREGS).

Ports:
- clk  in  1  clock.
- rstn  in  1  synchronous active-low reset.
- alloc_req  in  1  rename stage requests one tag this cycle.
- alloc_grant  out  1  combinational; alloc_req && !empty.
- alloc_preg  out  TAG_W  combinational; tag at head, valid whenever !empty.
- free0_valid  in  1  ROB retire slot 0 frees a tag.
- free0_preg  in  TAG_W  tag freed by slot 0.
- free1_valid  in  1  ROB retire slot 1 frees a tag.
- free1_preg  in  TAG_W  tag freed by slot 1.
- empty  out  1  registered; count==0. Rename stalls on this.
- almost_empty  out  1  registered; count<=1.
- free_count  out  TAG_W+1  registered number of free tags.
- free_err  out  1  sticky error flag; cleared only by reset.

Behaviour:
- Storage:
  - queue[NUM_PREGS] of TAG_W entries.
  - head and tail pointers, TAG_W bits each; they wrap modulo NUM_PREGS.
  - count register, TAG_W+1 bits.
  - in_list bit vector, NUM_PREGS bits.
- Reset (rstn=0 at a clk edge):
  - queue[i] = NUM_AREGS+i for i < NUM_PREGS-NUM_AREGS.
  - head=0, tail=NUM_PREGS-NUM_AREGS (0 when NUM_AREGS=0, i.e. full wrap).
  - count=NUM_PREGS-NUM_AREGS.
  - in_list[t]=1 for t>=NUM_AREGS, else 0.
  - free_err=0, empty=0, almost_empty=0, free_count=32 (defaults).
  - Reset overrides any alloc or free issued in the same cycle.
- Allocate:
  - alloc_preg = queue[head], driven combinationally.
  - On a clk edge with alloc_grant=1: head+=1, in_list[alloc_preg]=0, count decrements.
  - Zero-latency handshake: a tag granted in cycle N is owned by rename from cycle N.
  - alloc_req while empty: no grant, no state change.
- Free acceptance per slot (s=0,1), tag t is accepted iff all hold:
  - frees_valid.
  - t >= NUM_AREGS is not required, but t != 0; p0 is hardwired for x0 and its free is silently ignored with no error.
  - in_list[t]==0.
  - For slot 1 only: not (free0 accepted && free1_preg==free0_preg).
- Free rejection: a valid free with t!=0 that fails acceptance is dropped and sets free_err=1.
- Free write:
  - Accepted slot 0 writes queue[tail]; accepted slot 1 writes queue[tail+n0], where n0 = slot 0 accepted (0/1).
  - tail += n0+n1.
  - in_list set for each accepted tag.
- Simultaneous alloc and free:
  - count_next = count - grant + n0 + n1.
  - Tags freed in cycle N are not visible to alloc until cycle N+1; no bypass. When empty, alloc is denied even if frees arrive the same cycle.
  - Allocating the tag at head while freeing a different tag to tail in the same cycle is legal at any fill level.
- Full: count==NUM_PREGS is reachable only if NUM_AREGS=0. The in_list check makes overflow impossible, because every tag is unique. Pointers wrap through index NUM_PREGS-1 to 0 without a gap.
- Registered status outputs (empty, almost_empty, free_count) reflect count_next after the edge; one-cycle visibility.
- Ordering: the FIFO returns tags in free order; slot 0 precedes slot 1 within a cycle.

Test Plan:
- Reset then idle:
  - free_count=32, empty=0, alloc_preg=32.
  - Hold alloc_req for 3 cycles -> grants return tags 32, 33, 34; free_count=29.
- Drain:
  - 32 consecutive allocs -> last tag 63; then empty=1, almost_empty=1.
  - A 33rd request gives alloc_grant=0 and no state change.
- Dual free after drain:
  - free0=40, free1=35 in one cycle, with alloc_req=1 the same cycle -> no grant that cycle.
  - Next cycle free_count=2 and alloc_preg=40; the following alloc returns 35.
- Double-free and x0:
  - free0=50 while 50 is still in the list -> dropped, free_err=1, count unchanged.
  - free0=free1=45 with 45 allocated -> one copy accepted, free_err=1.
  - free of tag 0 -> ignored, free_err unchanged.
- Wrap-around: 200 cycles of random alloc plus 0-2 valid frees of held tags -> scoreboard:
  - no tag is ever granted twice while held.
  - free_count matches the model.
  - head and tail wrap past 63 correctly.
- Mid-operation reset: rstn=0 while alloc_req=1 and both frees are valid -> the next cycle exactly matches the reset state (free_count=32, alloc_preg=32, free_err=0).

Source files
------------

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical register tags between ROB retire and rename.
// One tag allocated per cycle, up to two freed per cycle, guarded by an allocation bitmap.
module phys_reg_free_list #(
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned NUM_AREGS = 32,
  parameter int unsigned TAG_W     = $clog2(NUM_PREGS)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             alloc_req,
  output logic             alloc_grant,
  output logic [TAG_W-1:0] alloc_preg,
  input  logic             free0_valid,
  input  logic [TAG_W-1:0] free0_preg,
  input  logic             free1_valid,
  input  logic [TAG_W-1:0] free1_preg,
  output logic             empty,
  output logic             almost_empty,
  output logic [TAG_W:0]   free_count,
  output logic             free_err
);

  localparam int unsigned      NumFree  = NUM_PREGS - NUM_AREGS;
  localparam logic [TAG_W:0]   RstCount = (TAG_W + 1)'(NumFree);
  // Truncation yields 0 when every tag starts free (full wrap).
  localparam logic [TAG_W-1:0] RstTail  = TAG_W'(NumFree);

  logic [TAG_W-1:0]     queue_q [NUM_PREGS];
  logic [TAG_W-1:0]     queue_d [NUM_PREGS];
  logic [TAG_W-1:0]     head_q, head_d;
  logic [TAG_W-1:0]     tail_q, tail_d;
  logic [TAG_W-1:0]     tail1;
  logic [TAG_W:0]       count_q, count_d;
  logic [NUM_PREGS-1:0] in_list_q, in_list_d;
  logic                 free_err_q, free_err_d;
  logic                 empty_q, almost_empty_q;
  logic                 acc0, acc1, rej0, rej1;

  assign alloc_grant  = alloc_req && !empty_q;
  assign alloc_preg   = queue_q[head_q];
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;
  assign free_count   = count_q;
  assign free_err     = free_err_q;

  always_comb begin
    // Acceptance uses the bitmap as it stood at the start of the cycle.
    acc0 = free0_valid && (free0_preg != '0) && !in_list_q[free0_preg];
    rej0 = free0_valid && (free0_preg != '0) && !acc0;
    acc1 = free1_valid && (free1_preg != '0) && !in_list_q[free1_preg] &&
           !(acc0 && (free1_preg == free0_preg));
    rej1 = free1_valid && (free1_preg != '0) && !acc1;

    queue_d    = queue_q;
    in_list_d  = in_list_q;
    head_d     = head_q;
    free_err_d = free_err_q | rej0 | rej1;
    tail1      = tail_q + TAG_W'(acc0);

    if (alloc_grant) begin
      head_d                = head_q + TAG_W'(1);
      in_list_d[alloc_preg] = 1'b0;
    end
    if (acc0) begin
      queue_d[tail_q]       = free0_preg;
      in_list_d[free0_preg] = 1'b1;
    end
    if (acc1) begin
      queue_d[tail1]        = free1_preg;
      in_list_d[free1_preg] = 1'b1;
    end

    tail_d  = tail_q + TAG_W'(acc0) + TAG_W'(acc1);
    count_d = count_q - (TAG_W + 1)'(alloc_grant) + (TAG_W + 1)'(acc0) + (TAG_W + 1)'(acc1);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NUM_PREGS; i++) begin
        queue_q[i]   <= (i < NumFree) ? TAG_W'(NUM_AREGS + i) : '0;
        in_list_q[i] <= (i >= NUM_AREGS);
      end
      head_q         <= '0;
      tail_q         <= RstTail;
      count_q        <= RstCount;
      free_err_q     <= 1'b0;
      empty_q        <= (RstCount == '0);
      almost_empty_q <= (RstCount <= (TAG_W + 1)'(1));
    end else begin
      queue_q        <= queue_d;
      in_list_q      <= in_list_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      free_err_q     <= free_err_d;
      empty_q        <= (count_d == '0);
      almost_empty_q <= (count_d <= (TAG_W + 1)'(1));
    end
  end

endmodule

// File: tb/tb_phys_reg_free_list.sv
// Scoreboard bench for phys_reg_free_list: a queue-based free-list model predicts grants,
// tags and status; a negedge monitor pops and compares.
module tb_phys_reg_free_list;

  localparam int NP = 64;
  localparam int NA = 32;
  localparam int TW = 6;

  logic          clk = 1'b0;
  logic          rstn;
  logic          alloc_req;
  logic          alloc_grant;
  logic [TW-1:0] alloc_preg;
  logic          free0_valid;
  logic [TW-1:0] free0_preg;
  logic          free1_valid;
  logic [TW-1:0] free1_preg;
  logic          empty;
  logic          almost_empty;
  logic [TW:0]   free_count;
  logic          free_err;

  phys_reg_free_list #(
    .NUM_PREGS (NP),
    .NUM_AREGS (NA),
    .TAG_W     (TW)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .alloc_req    (alloc_req),
    .alloc_grant  (alloc_grant),
    .alloc_preg   (alloc_preg),
    .free0_valid  (free0_valid),
    .free0_preg   (free0_preg),
    .free1_valid  (free1_valid),
    .free1_preg   (free1_preg),
    .empty        (empty),
    .almost_empty (almost_empty),
    .free_count   (free_count),
    .free_err     (free_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        grant;
    logic [TW:0] cnt;
    logic        emp;
    logic        aemp;
    logic        err;
  } exp_t;

  exp_t          st_q[$];
  logic [TW-1:0] tag_q[$];
  int            fl[$];     // model: free tags in FIFO order
  bit            inl[NP];   // model: tag currently sits in the free list
  bit            merr;
  bit            mon_en = 1'b0;
  int            vectors = 0;
  int            miscompares = 0;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    fl.delete();
    for (int i = 0; i < NP; i++) begin
      inl[i] = (i >= NA);
      if (i >= NA) fl.push_back(i);
    end
    merr = 1'b0;
  endfunction

  // Drive one cycle of stimulus, record expectations, advance the model, wait for the edge.
  task automatic step(input bit rst, input bit req, input bit v0, input int t0,
                      input bit v1, input int t1);
    exp_t e;
    bit   g, a0, a1;
    int   tag;
    rstn        = !rst;
    alloc_req   = req;
    free0_valid = v0;
    free0_preg  = TW'(t0);
    free1_valid = v1;
    free1_preg  = TW'(t1);
    g      = req && (fl.size() > 0);
    e.grant = g;
    e.cnt   = (TW + 1)'(fl.size());
    e.emp   = (fl.size() == 0);
    e.aemp  = (fl.size() <= 1);
    e.err   = merr;
    st_q.push_back(e);
    if (g) tag_q.push_back(TW'(fl[0]));
    if (rst) begin
      model_reset();
    end else begin
      a0 = v0 && (t0 != 0) && !inl[t0];
      a1 = v1 && (t1 != 0) && !inl[t1] && !(a0 && (t1 == t0));
      if ((v0 && (t0 != 0) && !a0) || (v1 && (t1 != 0) && !a1)) merr = 1'b1;
      if (g) begin
        tag = fl.pop_front();
        inl[tag] = 1'b0;
      end
      if (a0) begin fl.push_back(t0); inl[t0] = 1'b1; end
      if (a1) begin fl.push_back(t1); inl[t1] = 1'b1; end
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (mon_en) begin
      if (st_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL status_queue: got no expectation, expected one per cycle");
      end else begin
        e = st_q.pop_front();
        cmp("alloc_grant", 32'(alloc_grant), 32'(e.grant));
        cmp("free_count", 32'(free_count), 32'(e.cnt));
        cmp("empty", 32'(empty), 32'(e.emp));
        cmp("almost_empty", 32'(almost_empty), 32'(e.aemp));
        cmp("free_err", 32'(free_err), 32'(e.err));
      end
      if (alloc_grant === 1'b1) begin
        if (tag_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL alloc_preg: got grant of %0d, expected no grant", alloc_preg);
        end else begin
          cmp("alloc_preg", 32'(alloc_preg), 32'(tag_q.pop_front()));
        end
      end
    end
  end

  function automatic int pick_held(input int avoid);
    int h[$];
    for (int t = 1; t < NP; t++) if (!inl[t] && t != avoid) h.push_back(t);
    if (h.size() == 0) return -1;
    return h[$urandom_range(0, h.size() - 1)];
  endfunction

  initial begin : stim
    int t0, t1, nf;
    bit v0, v1;
    rstn = 1'b0; alloc_req = 1'b0;
    free0_valid = 1'b0; free0_preg = '0; free1_valid = 1'b0; free1_preg = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cmp("rst_free_count", 32'(free_count), 32'd32);
    cmp("rst_empty", 32'(empty), 32'd0);
    cmp("rst_alloc_preg", 32'(alloc_preg), 32'd32);
    mon_en = 1'b1;

    // x0 frees are silently ignored
    step(0, 0, 1, 0, 1, 0);
    cmp("x0_free_err", 32'(free_err), 32'd0);
    cmp("x0_free_count", 32'(free_count), 32'd32);

    repeat (3) step(0, 1, 0, 0, 0, 0);
    cmp("three_alloc_count", 32'(free_count), 32'd29);
    repeat (29) step(0, 1, 0, 0, 0, 0);
    cmp("drain_empty", 32'(empty), 32'd1);
    cmp("drain_almost_empty", 32'(almost_empty), 32'd1);
    step(0, 1, 0, 0, 0, 0);
    cmp("empty_req_count", 32'(free_count), 32'd0);

    // dual free while empty: no bypass to the same-cycle request
    step(0, 1, 1, 40, 1, 35);
    cmp("dual_free_count", 32'(free_count), 32'd2);
    cmp("dual_free_head", 32'(alloc_preg), 32'd40);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);

    step(0, 0, 1, 50, 0, 0);
    step(0, 0, 1, 50, 0, 0);
    cmp("double_free_err", 32'(free_err), 32'd1);
    cmp("double_free_count", 32'(free_count), 32'd1);
    step(0, 0, 1, 45, 1, 45);
    cmp("same_slot_dup_count", 32'(free_count), 32'd2);
    step(0, 0, 1, 0, 0, 0);

    // Random traffic from a fresh reset; frees drawn from held tags, occasional bad ones
    step(1, 0, 0, 0, 0, 0);
    for (int c = 0; c < 200; c++) begin
      nf = $urandom_range(0, 2);
      t0 = pick_held(-1);
      t1 = pick_held(t0);
      v0 = (nf >= 1) && (t0 > 0);
      v1 = (nf == 2) && (t1 > 0);
      if (c > 100 && $urandom_range(0, 24) == 0) begin
        v1 = 1'b1;
        t1 = ($urandom_range(0, 1) == 0 && fl.size() > 0) ? fl[$urandom_range(0, fl.size() - 1)]
                                                           : t0;
        if (t1 < 0) t1 = 0;
      end
      if (t0 < 0) t0 = 0;
      if (t1 < 0) t1 = 0;
      step(0, $urandom_range(0, 99) < 55, v0, t0, v1, t1);
    end

    // Mid-operation reset with alloc and both frees active
    t0 = pick_held(-1);
    t1 = pick_held(t0);
    if (t0 < 0) t0 = 1;
    if (t1 < 0) t1 = 2;
    step(1, 1, 1, t0, 1, t1);
    cmp("midrst_free_count", 32'(free_count), 32'd32);
    cmp("midrst_alloc_preg", 32'(alloc_preg), 32'd32);
    cmp("midrst_free_err", 32'(free_err), 32'd0);
    cmp("midrst_empty", 32'(empty), 32'd0);
    repeat (4) step(0, 1, 0, 0, 0, 0);

    mon_en = 1'b0;
    cmp("pending_grants", 32'(tag_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
